// File: rtl/axis_iic_bridge_arbiter_pkg.sv
// Shared types and the round-robin winner function for the IIC bridge arbiter.
package axis_iic_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_FWD_CMD,
        ARB_WAIT_RSP,
        ARB_FWD_RSP,
        ARB_TO_RSP
    } arb_state_t;

    localparam int RR_MAX_PORTS = 8;

    // First requester at or after last+1 (mod n); returns last when nobody requests.
    function automatic logic [2:0] rr_next(input logic [RR_MAX_PORTS-1:0] req,
                                           input logic [2:0]              last,
                                           input int                      n);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX_PORTS; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && !found && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_iic_bridge_arbiter_if.sv
// AXI-Stream bundle with LANES parallel lanes sharing one set of wires.
interface axis_iic_bridge_arbiter_if #(
    parameter int LANES   = 1,
    parameter int N_BYTES = 32
);
    logic [LANES*N_BYTES*8-1:0] tdata;
    logic [LANES*N_BYTES-1:0]   tkeep;
    logic [LANES*8-1:0]         tuser;
    logic [LANES-1:0]           tvalid;
    logic [LANES-1:0]           tlast;
    logic [LANES-1:0]           tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_iic_bridge_arbiter_rr_grant.sv
// Round-robin request/grant: combinational winner, last_grant updated on grant_en.
module axis_rr_grant
    import axis_iic_arb_pkg::*;
#(
    parameter int  N_PORTS = 4,
    localparam int GW      = $clog2(N_PORTS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PORTS-1:0] req_i,
    input  logic               grant_en_i,
    output logic [GW-1:0]      winner_o
);
    logic [GW-1:0]           last_grant_q;
    logic [RR_MAX_PORTS-1:0] req_ext;
    logic [2:0]              last_ext;
    logic [2:0]              win_ext;

    assign req_ext  = RR_MAX_PORTS'(req_i);
    assign last_ext = 3'(last_grant_q);
    assign win_ext  = rr_next(req_ext, last_ext, N_PORTS);
    assign winner_o = GW'(win_ext);

    // Reset to the last port so port 0 is served first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= GW'(N_PORTS - 1);
        end else if (grant_en_i) begin
            last_grant_q <= winner_o;
        end
    end
endmodule

// File: rtl/axis_iic_bridge_arbiter.sv
// Shares one axis_iic_bridge between N_PORTS requesters; holds the grant until
// the response (or a timeout error beat) has been returned to the owner.
module axis_iic_bridge_arbiter
    import axis_iic_arb_pkg::*;
#(
    parameter int  N_PORTS        = 4,
    parameter int  N_BYTES        = 32,
    parameter int  TIMEOUT_CYCLES = 1000000,
    localparam int GW             = $clog2(N_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    axis_iic_bridge_arbiter_if.slave    s_axis,
    axis_iic_bridge_arbiter_if.master   m_axis,
    axis_iic_bridge_arbiter_if.master   br_s_axis,
    axis_iic_bridge_arbiter_if.slave    br_m_axis,
    output logic [GW-1:0]               grant_id,
    output logic                        busy,
    output logic                        timeout_pulse
);
    localparam int DW = N_BYTES * 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_t    state_q;
    logic [GW-1:0] grant_q;
    logic [7:0]    cmd_addr_q;
    logic [CW-1:0] to_cnt_q;
    logic          busy_q;
    logic          timeout_pulse_q;

    logic [GW-1:0] rr_winner;
    logic          req_any;
    logic          grant_en;
    logic [7:0]    win_user;
    logic          to_rdy;
    logic          rsp_phase;
    logic          cmd_done;
    logic          rsp_fire;

    assign req_any   = |s_axis.tvalid;
    assign grant_en  = (state_q == ARB_IDLE) && req_any;
    assign rsp_phase = (state_q == ARB_WAIT_RSP) || (state_q == ARB_FWD_RSP);
    assign cmd_done  = br_s_axis.tvalid && br_s_axis.tready && br_s_axis.tlast;
    assign rsp_fire  = br_m_axis.tvalid && br_m_axis.tready;

    axis_rr_grant #(.N_PORTS(N_PORTS)) u_rr_grant (
        .clk        (clk),
        .reset      (reset),
        .req_i      (s_axis.tvalid),
        .grant_en_i (grant_en),
        .winner_o   (rr_winner)
    );

    always_comb begin
        win_user = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (rr_winner == GW'(i)) win_user = s_axis.tuser[i*8 +: 8];
        end
    end

    always_comb begin
        br_s_axis.tdata  = '0;
        br_s_axis.tkeep  = '0;
        br_s_axis.tuser  = '0;
        br_s_axis.tvalid = '0;
        br_s_axis.tlast  = '0;
        s_axis.tready    = '0;
        m_axis.tdata     = '0;
        m_axis.tkeep     = '0;
        m_axis.tuser     = '0;
        m_axis.tvalid    = '0;
        m_axis.tlast     = '0;
        br_m_axis.tready = '0;
        to_rdy           = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q == GW'(i)) begin
                if (state_q == ARB_FWD_CMD) begin
                    br_s_axis.tdata  = s_axis.tdata[i*DW +: DW];
                    br_s_axis.tkeep  = s_axis.tkeep[i*N_BYTES +: N_BYTES];
                    br_s_axis.tuser  = s_axis.tuser[i*8 +: 8];
                    br_s_axis.tvalid = s_axis.tvalid[i];
                    br_s_axis.tlast  = s_axis.tlast[i];
                    s_axis.tready[i] = br_s_axis.tready;
                end
                // The first response beat is already routed while waiting.
                if (rsp_phase) begin
                    m_axis.tdata[i*DW +: DW]           = br_m_axis.tdata;
                    m_axis.tkeep[i*N_BYTES +: N_BYTES] = br_m_axis.tkeep;
                    m_axis.tuser[i*8 +: 8]             = br_m_axis.tuser;
                    m_axis.tvalid[i]                   = br_m_axis.tvalid;
                    m_axis.tlast[i]                    = br_m_axis.tlast;
                    br_m_axis.tready                   = m_axis.tready[i];
                end
                if (state_q == ARB_TO_RSP) begin
                    m_axis.tuser[i*8 +: 8] = cmd_addr_q;
                    m_axis.tvalid[i]       = 1'b1;
                    m_axis.tlast[i]        = 1'b1;
                    to_rdy                 = m_axis.tready[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ARB_IDLE;
            grant_q         <= '0;
            cmd_addr_q      <= '0;
            to_cnt_q        <= '0;
            busy_q          <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            timeout_pulse_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (req_any) begin
                        grant_q    <= rr_winner;
                        cmd_addr_q <= win_user;
                        state_q    <= ARB_FWD_CMD;
                        busy_q     <= 1'b1;
                    end
                end
                ARB_FWD_CMD: begin
                    if (cmd_done) begin
                        to_cnt_q <= '0;
                        state_q  <= ARB_WAIT_RSP;
                    end
                end
                ARB_WAIT_RSP: begin
                    if (br_m_axis.tvalid) begin
                        if (rsp_fire && br_m_axis.tlast) begin
                            state_q <= ARB_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ARB_FWD_RSP;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q         <= ARB_TO_RSP;
                        timeout_pulse_q <= 1'b1;
                    end else if (to_cnt_q != '1) begin
                        to_cnt_q <= to_cnt_q + CW'(1);
                    end
                end
                ARB_FWD_RSP: begin
                    if (rsp_fire && br_m_axis.tlast) begin
                        state_q <= ARB_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ARB_TO_RSP: begin
                    if (to_rdy) begin
                        state_q <= ARB_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id      = grant_q;
    assign busy          = busy_q;
    assign timeout_pulse = timeout_pulse_q;
endmodule

// File: doc/axis_iic_bridge_arbiter.md
# axis_iic_bridge_arbiter

Shares one `axis_iic_bridge` instance between `N_PORTS` AXI-Stream requesters. Command packets are granted round-robin and forwarded whole. The arbiter then holds the grant until the bridge's response packet has been routed back to the same requester. A missing response is closed with a timeout error beat. The block sits between the requesting masters (CPU DMA, sensor pollers) and the bridge's `s_axis_*`/`m_axis_*` ports.

## Interface
- `N_PORTS`, 4: number of requesters, 2..8.
- `N_BYTES`, 32: bytes per beat; must match the bridge. `DATA_WIDTH = N_BYTES*8`.
- `TIMEOUT_CYCLES`, 1000000: maximum `clk` cycles to wait for the first response beat.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `s_axis_tdata` in `N_PORTS*DATA_WIDTH`: requester commands, flat; port `i` occupies slice `i`. `tkeep` (`N_PORTS*N_BYTES`), `tuser` (`N_PORTS*8`, I2C address + R/W), `tvalid`/`tlast` (`N_PORTS`) in; `tready` (`N_PORTS`) out.
- `m_axis_tdata` out `N_PORTS*DATA_WIDTH`: responses, flat, same slicing. `tkeep`, `tuser`, `tvalid`, `tlast` out; `tready` (`N_PORTS`) in.
- `br_s_axis_*` out (`tready` in): command stream to the bridge, `DATA_WIDTH`/`N_BYTES`/8/1/1/1.
- `br_m_axis_*` in (`tready` out): response stream from the bridge.
- `grant_id` out `$clog2(N_PORTS)`: current owner; valid while `busy`.
- `busy` out 1: a transaction is in progress.
- `timeout_pulse` out 1: single-cycle pulse when a timeout fires.

## Operation
States: IDLE, FWD_CMD, WAIT_RSP, FWD_RSP, TO_RSP.
- **IDLE**
  - When any `s_axis_tvalid[i]` is high, register the grant. The winner is the first requester at or after `last_grant+1 mod N_PORTS`.
  - Latch the winner's `tuser` into `cmd_addr`, set `last_grant = winner`, then go to FWD_CMD.
- **FWD_CMD**
  - Granted requester's `s_axis_*` is muxed combinationally onto `br_s_axis_*`. `s_axis_tready[grant]` = `br_s_axis_tready`; all other `s_axis_tready` = 0.
  - Handshake with `tlast` = 1 goes to WAIT_RSP and clears `to_cnt`.
- **WAIT_RSP**
  - `to_cnt` increments each cycle.
  - First `br_m_axis` beat goes to FWD_RSP, and that beat is itself routed.
  - `to_cnt == TIMEOUT_CYCLES-1` with no beat goes to TO_RSP. Response wins if both occur in the same cycle.
- **FWD_RSP**
  - `br_m_axis_*` is demuxed to `m_axis[grant]`. `br_m_axis_tready` = `m_axis_tready[grant]`.
  - Handshake with `tlast` = 1 goes to IDLE.
  - No timeout applies once the response has started.
- **TO_RSP**
  - Drive `m_axis[grant]` with one beat: tdata = 0, tkeep = 0, tuser = `cmd_addr`, tlast = 1.
  - Pulse `timeout_pulse` on entry.
  - Handshake goes to IDLE.
- `br_m_axis_tready` = 0 outside WAIT_RSP/FWD_RSP. A stray bridge response is stalled, never dropped.
- Non-granted `m_axis_tvalid` = 0. Non-granted data outputs are don't-care but are driven 0.
- `to_cnt` width is `$clog2(TIMEOUT_CYCLES)+1` and saturates.

## Timing
- Reset values (asynchronous):
  - state = IDLE, `grant` = 0, `last_grant` = `N_PORTS-1` (so port 0 is served first), `to_cnt` = 0, `cmd_addr` = 0.
  - All `tvalid`/`tready` outputs = 0; `busy` = 0; `timeout_pulse` = 0.
- Arbitration latency: 1 cycle from `tvalid` to first possible forwarded beat.
- Forward and return paths have 0-cycle latency (combinational mux/demux). The only registers are state, grant, counter and address.
- `busy` = 1 in every state except IDLE, registered with the state.
- Back-to-back transactions: IDLE lasts exactly one cycle between a response `tlast` and the next grant.
- A requester that drops `tvalid` mid-packet simply stalls the bridge. The arbiter does not preempt.
- Reset mid-transaction returns everything to IDLE immediately; partial packets are abandoned. The bridge must be reset in the same domain.

## Structure
- Package `axis_iic_arb_pkg`:
  - state enum `arb_state_t`;
  - function `rr_next(req, last)` returning the winner index.
- Sub-module `axis_rr_grant`: round-robin request/grant with a `last_grant` register and a `grant_en` strobe. It is reusable by other axis_infrastructure arbiters.
- Top level holds the FSM, the timeout counter, and the mux/demux.

## Test plan
- **Single command.** Port 2 sends 1 beat, tuser = 0xA0; bridge responds 1 beat.
  - `br_s` sees tuser = 0xA0.
  - `m_axis[2]` gets the response.
  - `busy` is low 1 cycle after response `tlast`.
- **Round-robin fairness.** All 4 ports hold `tvalid` continuously.
  - Grant order is 0, 1, 2, 3, 0, …
  - No port is granted twice before the others.
- **Back-pressure.** Bridge `tready` toggles every other cycle on a 3-beat command; `m_axis_tready[1]` is held low for 20 cycles during the response.
  - Data arrives intact and in order.
  - No beats are lost or duplicated.
- **Timeout.** `TIMEOUT_CYCLES` = 16; bridge never responds to port 3's command with tuser = 0x51.
  - Exactly 16 cycles after command `tlast`, `timeout_pulse` = 1.
  - `m_axis[3]` gets tkeep = 0, tuser = 0x51, tlast = 1.
  - Next grant proceeds normally.
- **Reset mid-response.** Assert `reset` during beat 2 of a 4-beat response.
  - All `tvalid` = 0 and `busy` = 0 asynchronously.
  - After release, port 0 is granted first.
- **Response/timeout coincidence.** First response beat arrives exactly when `to_cnt == TIMEOUT_CYCLES-1`.
  - Response is forwarded.
  - No `timeout_pulse`.
